// File: rtl/qm_minterm_scanner_pkg.sv
// ----------------------------------------------------------------------------
// qm_pkg
// Shared constants and the scanner state type for qm_minterm_scanner.
//   N_VARS  : default number of evaluator inputs
//   TT_BITS : truth-table width (one bit per input combination)
//   IDX_W   : width of a minterm index / probe vector
// ----------------------------------------------------------------------------
package qm_pkg;

   localparam int N_VARS  = 6;
   localparam int TT_BITS = 2**N_VARS;
   localparam int IDX_W   = N_VARS;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_EMIT,
      S_DONE
   } state_t;

endpackage

// File: rtl/qm_minterm_scanner_if.sv
// ----------------------------------------------------------------------------
// qm_minterm_scanner_if
// Valid/ready stream carrying minterm indices out of the scanner.
//   m_valid : index on m_data is valid           (master -> slave)
//   m_data  : minterm index, N_VARS bits          (master -> slave)
//   m_ready : slave accepts when m_valid&m_ready  (slave -> master)
// ----------------------------------------------------------------------------
interface qm_minterm_scanner_if #(
   parameter int N_VARS = qm_pkg::IDX_W
);

   logic              m_valid;
   logic [N_VARS-1:0] m_data;
   logic              m_ready;

   modport master (
      output m_valid,
      output m_data,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      output m_ready
   );

endinterface

// File: rtl/qm_minterm_scanner_idx_counter.sv
// ----------------------------------------------------------------------------
// qm_idx_counter
// Index counter for the scanner; its register is the probe vector itself.
//   clk, reset : clock, synchronous active-high reset
//   i_clr      : synchronous clear to 0
//   i_en       : advance by one
//   o_idx      : current index
//   o_is_last  : index is the final combination (all ones)
// ----------------------------------------------------------------------------
module qm_idx_counter #(
   parameter int W = qm_pkg::IDX_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_idx,
   output logic         o_is_last
);

   logic [W-1:0] r_idx;

   always_ff @(posedge clk) begin
      if (reset || i_clr) begin
         r_idx <= '0;
      end else if (i_en) begin
         r_idx <= r_idx + 1'b1;
      end
   end

   assign o_idx     = r_idx;
   assign o_is_last = &r_idx;

endmodule

// File: rtl/qm_minterm_scanner.sv
// ----------------------------------------------------------------------------
// qm_minterm_scanner
// Walks every input combination of an N_VARS-input combinational evaluator,
// records its truth table and streams out each minterm index.
//   clk, reset    : clock, synchronous active-high reset
//   start         : one-cycle scan request, ignored while busy
//   probe         : input vector driven onto the evaluator
//   eval_in       : evaluator output for the current probe
//   m_if          : minterm index stream (master side)
//   truth_table   : bit i = evaluator output for probe i, held after a scan
//   minterm_count : number of ones found (N_VARS+1 bits, no wrap at full)
//   busy          : high in SCAN, EMIT and DONE
//   done          : one-cycle pulse while in DONE
//
// state  | meaning
// S_IDLE | waiting for start; results of the last scan held
// S_SCAN | sample eval_in for the current probe, one cycle per index
// S_EMIT | minterm offered on the stream, probe frozen until accepted
// S_DONE | done pulse, then back to idle
// ----------------------------------------------------------------------------
module qm_minterm_scanner #(
   parameter int N_VARS = qm_pkg::N_VARS
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   output logic [N_VARS-1:0]      probe,
   input  logic                   eval_in,
   qm_minterm_scanner_if.master   m_if,
   output logic [(2**N_VARS)-1:0] truth_table,
   output logic [N_VARS:0]        minterm_count,
   output logic                   busy,
   output logic                   done
);

   import qm_pkg::*;

   localparam int LP_TT = 2**N_VARS;

   state_t              r_state;
   logic                r_m_valid;
   logic [N_VARS-1:0]   r_m_data;
   logic [LP_TT-1:0]    r_tt;
   logic [N_VARS:0]     r_cnt;
   logic                r_busy;
   logic                r_done;

   logic [N_VARS-1:0]   w_idx;
   logic                w_is_last;
   logic                w_clr;
   logic                w_en;
   logic                w_hs;

   assign w_hs  = r_m_valid && m_if.m_ready;
   assign w_clr = (r_state == S_IDLE) && start;

   // Advance on a zero sample in SCAN, or on acceptance in EMIT; never past
   // the last index so probe stays at the final combination into DONE.
   assign w_en  = !w_is_last &&
                  (((r_state == S_SCAN) && !eval_in) ||
                   ((r_state == S_EMIT) && w_hs));

   qm_idx_counter #(
      .W (N_VARS)
   ) u_idx (
      .clk       (clk),
      .reset     (reset),
      .i_clr     (w_clr),
      .i_en      (w_en),
      .o_idx     (w_idx),
      .o_is_last (w_is_last)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state   <= S_IDLE;
         r_m_valid <= 1'b0;
         r_m_data  <= '0;
         r_tt      <= '0;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_tt    <= '0;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
                  r_state <= S_SCAN;
               end
            end
            S_SCAN: begin
               r_tt[w_idx] <= eval_in;
               if (eval_in) begin
                  r_m_valid <= 1'b1;
                  r_m_data  <= w_idx;
                  r_cnt     <= r_cnt + 1'b1;
                  r_state   <= S_EMIT;
               end else if (w_is_last) begin
                  r_done  <= 1'b1;
                  r_state <= S_DONE;
               end
            end
            S_EMIT: begin
               if (w_hs) begin
                  r_m_valid <= 1'b0;
                  if (w_is_last) begin
                     r_done  <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     r_state <= S_SCAN;
                  end
               end
            end
            S_DONE: begin
               r_busy  <= 1'b0;
               r_state <= S_IDLE;
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign probe         = w_idx;
   assign m_if.m_valid  = r_m_valid;
   assign m_if.m_data   = r_m_data;
   assign truth_table   = r_tt;
   assign minterm_count = r_cnt;
   assign busy          = r_busy;
   assign done          = r_done;

endmodule

// File: tb/tb_qm_minterm_scanner.sv
module tb_qm_minterm_scanner;

   localparam int NV = qm_pkg::N_VARS;
   localparam int TT = qm_pkg::TT_BITS;

   logic          clk;
   logic          reset;
   logic          start;
   logic [NV-1:0] probe;
   logic          eval_in;
   logic [TT-1:0] truth_table;
   logic [NV:0]   minterm_count;
   logic          busy;
   logic          done;

   int            mode;
   logic [TT-1:0] rand_tt;

   int checks   = 0;
   int failures = 0;

   qm_minterm_scanner_if #(.N_VARS(NV)) s_if ();

   qm_minterm_scanner #(.N_VARS(NV)) dut (
      .clk           (clk),
      .reset         (reset),
      .start         (start),
      .probe         (probe),
      .eval_in       (eval_in),
      .m_if          (s_if),
      .truth_table   (truth_table),
      .minterm_count (minterm_count),
      .busy          (busy),
      .done          (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Evaluator functions: 0 const-0, 1 const-1, 2 a&b&c&d&e&f, 3 lab4 SOP,
   // 4 arbitrary random table.
   function automatic logic eval_fn(input int md, input logic [5:0] x, input logic [TT-1:0] tbl);
      logic a, b, c, d, e, f;
      {a, b, c, d, e, f} = x;
      case (md)
         0:       return 1'b0;
         1:       return 1'b1;
         2:       return a & b & c & d & e & f;
         3:       return (a & b & ~c) | (~a & ~b & d) | (c & ~d & f) | (b & e & ~f);
         default: return tbl[x];
      endcase
   endfunction

   assign eval_in = eval_fn(mode, probe, rand_tt);

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   // Runs one complete scan and checks it against a truth table computed
   // directly from the evaluator function.
   task automatic do_scan(input int md, input int rdy_pct, input bit extra_start, input string tag);
      logic [TT-1:0] exp_tt;
      int            exp_q[$];
      int            got_q[$];
      int            cyc, done_cyc, stalls;
      logic          pv, pr;
      logic [NV-1:0] pd;
      bit            seq_ok;

      exp_tt = '0;
      for (int i = 0; i < TT; i++) begin
         exp_tt[i] = eval_fn(md, i[5:0], rand_tt);
         if (exp_tt[i]) exp_q.push_back(i);
      end

      @(negedge clk);
      mode = md;
      start = 1'b1;
      s_if.m_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc = 1; done_cyc = -1; stalls = 0; pv = 1'b0; pr = 1'b0; pd = '0;

      while (done_cyc < 0 && cyc < 3000) begin
         if (pv && !pr) begin
            checks++;
            if (s_if.m_valid !== 1'b1 || s_if.m_data !== pd) begin
               failures++;
               $display("FAIL %s stall_hold cyc=%0d got valid=%b data=%0d exp valid=1 data=%0d",
                        tag, cyc, s_if.m_valid, s_if.m_data, pd);
            end
         end
         if (done === 1'b1) begin
            done_cyc = cyc;
            checks++;
            if (busy !== 1'b1) begin
               failures++;
               $display("FAIL %s busy_in_done got=%b exp=1", tag, busy);
            end
         end
         s_if.m_ready = ($urandom_range(0, 99) < rdy_pct);
         if (s_if.m_valid === 1'b1 && s_if.m_ready) got_q.push_back(int'(s_if.m_data));
         if (s_if.m_valid === 1'b1 && !s_if.m_ready) stalls++;
         pv = s_if.m_valid; pr = s_if.m_ready; pd = s_if.m_data;
         start = extra_start && (cyc == 10 || cyc == 30 || cyc == done_cyc);
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      s_if.m_ready = 1'b1;

      checks++;
      if (done_cyc < 0) begin
         failures++;
         $display("FAIL %s done_timeout got=none exp=done pulse", tag);
      end else begin
         checks++;
         if (done_cyc != 65 + exp_q.size() + stalls) begin
            failures++;
            $display("FAIL %s done_cycle got=%0d exp=%0d", tag, done_cyc, 65 + exp_q.size() + stalls);
         end
      end

      checks++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL %s after_done got done=%b busy=%b exp done=0 busy=0", tag, done, busy);
      end
      checks++;
      if (truth_table !== exp_tt) begin
         failures++;
         $display("FAIL %s truth_table got=%h exp=%h", tag, truth_table, exp_tt);
      end
      checks++;
      if (minterm_count !== exp_q.size()) begin
         failures++;
         $display("FAIL %s minterm_count got=%0d exp=%0d", tag, minterm_count, exp_q.size());
      end
      seq_ok = (got_q.size() == exp_q.size());
      if (seq_ok) foreach (exp_q[k]) if (got_q[k] != exp_q[k]) seq_ok = 1'b0;
      checks++;
      if (!seq_ok) begin
         failures++;
         $display("FAIL %s m_data_sequence got_len=%0d exp_len=%0d first_got=%0d first_exp=%0d",
                  tag, got_q.size(), exp_q.size(),
                  (got_q.size() > 0) ? got_q[0] : -1, (exp_q.size() > 0) ? exp_q[0] : -1);
      end
      repeat (2) @(negedge clk);
      checks++;
      if (truth_table !== exp_tt || minterm_count !== exp_q.size()) begin
         failures++;
         $display("FAIL %s results_hold got tt=%h cnt=%0d exp tt=%h cnt=%0d",
                  tag, truth_table, minterm_count, exp_tt, exp_q.size());
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (s_if.m_valid !== 1'b0 || s_if.m_data !== '0 || probe !== '0 || truth_table !== '0 ||
          minterm_count !== '0 || busy !== 1'b0 || done !== 1'b0) begin
         failures++;
         $display("FAIL %s outputs_zero got valid=%b data=%0d probe=%0d tt=%h cnt=%0d busy=%b done=%b exp all 0",
                  tag, s_if.m_valid, s_if.m_data, probe, truth_table, minterm_count, busy, done);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; start = 1'b0; s_if.m_ready = 1'b1; mode = 0;
      repeat (3) @(negedge clk);
      check_all_zero("reset");
      reset = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("idle_after_reset");
   endtask

   task automatic test_const0();
      do_scan(0, 100, 1'b0, "const0");
   endtask

   task automatic test_const1();
      do_scan(1, 100, 1'b0, "const1");
   endtask

   task automatic test_and6();
      do_scan(2, 100, 1'b0, "and6");
   endtask

   task automatic test_lab4_random_ready();
      do_scan(3, 50, 1'b0, "lab4_rdy50");
      do_scan(3, 25, 1'b0, "lab4_rdy25");
   endtask

   task automatic test_random_tables();
      for (int t = 0; t < 3; t++) begin
         rand_tt = {$urandom, $urandom};
         do_scan(4, 60, 1'b0, "rand_table");
      end
   endtask

   task automatic test_backpressure();
      int n, cyc;
      @(negedge clk);
      mode = 1; s_if.m_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 1; n = 0;
      while (!(s_if.m_valid === 1'b1 && s_if.m_data === 6'd5) && n < 100) begin
         @(negedge clk); n++; cyc++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL bp reach_index5 got=timeout exp=m_valid with m_data=5");
      end
      s_if.m_ready = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk); cyc++;
         checks++;
         if (s_if.m_valid !== 1'b1 || s_if.m_data !== 6'd5 || probe !== 6'd5) begin
            failures++;
            $display("FAIL bp stall%0d got valid=%b data=%0d probe=%0d exp valid=1 data=5 probe=5",
                     k, s_if.m_valid, s_if.m_data, probe);
         end
      end
      s_if.m_ready = 1'b1;
      @(negedge clk); cyc++;
      checks++;
      if (s_if.m_valid !== 1'b0 || probe !== 6'd6) begin
         failures++;
         $display("FAIL bp resume_scan got valid=%b probe=%0d exp valid=0 probe=6", s_if.m_valid, probe);
      end
      @(negedge clk); cyc++;
      checks++;
      if (s_if.m_valid !== 1'b1 || s_if.m_data !== 6'd6) begin
         failures++;
         $display("FAIL bp next_minterm got valid=%b data=%0d exp valid=1 data=6", s_if.m_valid, s_if.m_data);
      end
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         @(negedge clk); n++; cyc++;
      end
      checks++;
      if (cyc != 139) begin
         failures++;
         $display("FAIL bp done_cycle got=%0d exp=139", cyc);
      end
      checks++;
      if (minterm_count !== 7'd64 || truth_table !== {TT{1'b1}}) begin
         failures++;
         $display("FAIL bp results got cnt=%0d tt=%h exp cnt=64 tt=all ones", minterm_count, truth_table);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset_mid_emit();
      int n;
      @(negedge clk);
      mode = 1; s_if.m_ready = 1'b1; start = 1'b1;
      @(negedge clk);
      start = 1'b0; n = 0;
      while (!(s_if.m_valid === 1'b1 && s_if.m_data === 6'd20) && n < 100) begin
         @(negedge clk); n++;
      end
      checks++;
      if (n >= 100) begin
         failures++;
         $display("FAIL rst_mid reach_index20 got=timeout exp=m_valid with m_data=20");
      end
      s_if.m_ready = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      check_all_zero("rst_mid_emit");
      reset = 1'b0;
      s_if.m_ready = 1'b1;
      repeat (3) @(negedge clk);
      check_all_zero("rst_mid_stays_idle");
      do_scan(1, 100, 1'b0, "clean_after_reset");
   endtask

   task automatic test_second_start();
      do_scan(0, 100, 1'b1, "second_start_c0");
      do_scan(3, 60, 1'b1, "second_start_lab4");
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; mode = 0; rand_tt = '0; s_if.m_ready = 1'b1;
      test_reset();
      test_const0();
      test_const1();
      test_and6();
      test_lab4_random_ready();
      test_random_tables();
      test_backpressure();
      test_reset_mid_emit();
      test_second_start();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
